// File: rtl/conv3x3_window_mac.sv
// conv3x3_window_mac: sliding 3x3 window over line-buffer taps convolved with a
// runtime-loadable signed kernel through a 4-stage pipeline, clamped output.
module conv3x3_window_mac #(
    parameter int IMG_W  = 480,
    parameter int PIX_W  = 10,
    parameter int COEF_W = 8,
    parameter int SHIFT  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [PIX_W-1:0]  row0,
    input  logic [PIX_W-1:0]  row1,
    input  logic [PIX_W-1:0]  row2,
    input  logic              mat_flag,
    input  logic              sync_clr,
    input  logic              k_wr_en,
    input  logic [3:0]        k_addr,
    input  logic [COEF_W-1:0] k_data,
    output logic [PIX_W-1:0]  dout,
    output logic              dout_valid,
    output logic              line_last
);
    localparam int PW = PIX_W + COEF_W + 1;
    localparam int SW = PW + 2;
    localparam int FW = PW + 4;
    localparam int CW = $clog2(IMG_W);

    logic [CW-1:0]            col_cnt;
    logic [PIX_W-1:0]         win  [3][3];
    logic [PIX_W-1:0]         tap  [3];
    logic signed [COEF_W-1:0] kern [9];
    logic signed [PW-1:0]     prod [9];
    logic signed [SW-1:0]     psum [3];
    logic [2:0]               vld, lst;
    logic                     qual, at_end;
    logic signed [FW-1:0]     sum, shf;
    logic [PIX_W-1:0]         clamped;

    always_comb begin
        tap[0]  = row0;
        tap[1]  = row1;
        tap[2]  = row2;
        qual    = mat_flag && col_cnt >= CW'(2);
        at_end  = col_cnt == CW'(IMG_W - 1);
        sum     = psum[0] + psum[1] + psum[2];
        shf     = sum >>> SHIFT;
        // Sign bit set -> 0; any bit above the pixel range -> saturate.
        clamped = shf[FW-1] ? '0 : (|shf[FW-2:PIX_W]) ? '1 : shf[PIX_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt    <= '0;
            vld        <= '0;
            lst        <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            line_last  <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                psum[r] <= '0;
                for (int c = 0; c < 3; c++) win[r][c] <= '0;
            end
            for (int i = 0; i < 9; i++) begin
                prod[i] <= '0;
                kern[i] <= (i == 4) ? COEF_W'(1 << SHIFT) : '0;
            end
        end else begin
            for (int i = 0; i < 9; i++)
                if (k_wr_en && k_addr == 4'(i)) kern[i] <= k_data;
            if (sync_clr) begin
                col_cnt    <= '0;
                vld        <= '0;
                lst        <= '0;
                dout_valid <= 1'b0;
                line_last  <= 1'b0;
            end else begin
                if (mat_flag) begin
                    col_cnt <= at_end ? '0 : col_cnt + 1'b1;
                    for (int r = 0; r < 3; r++) begin
                        win[r][0] <= win[r][1];
                        win[r][1] <= win[r][2];
                        win[r][2] <= tap[r];
                    end
                end
                vld        <= {vld[1:0], qual};
                lst        <= {lst[1:0], qual && at_end};
                dout_valid <= vld[2];
                line_last  <= lst[2];
            end
            for (int r = 0; r < 3; r++) begin
                psum[r] <= prod[3*r] + prod[3*r+1] + prod[3*r+2];
                for (int c = 0; c < 3; c++)
                    prod[3*r+c] <= $signed({1'b0, win[r][c]}) * kern[3*r+c];
            end
            dout <= clamped;
        end
    end
endmodule
